// File: rtl/clock_stepper_pkg.sv
// Shared types and constants for the CPU clock stepper.
// Optional step counter in the top module is enabled by CLOCK_STEPPER_COUNT_EN.
package clock_stepper_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PULSE    = 2'd1,
        S_WAIT_REL = 2'd2
    } step_state_t;

    // Counter width that holds 0..n-1, never narrower than one bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes an active-low raw push button, inverts it, and debounces it
// into an active-high stable level.
module button_debouncer
    import clock_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic stable
);

    localparam int CW = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_btn;
    logic [CW-1:0]          count;

    // Presets to all ones so a released button looks released out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign sync_btn = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (sync_btn == stable) begin
            count <= '0;
        end else if (count == LAST) begin
            stable <= sync_btn;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clock_stepper.sv
// Single-cycle CPU clock enable: free-run divider or one step per debounced press.
// Define CLOCK_STEPPER_COUNT_EN to add the step_count debug output.
module clock_stepper
    import clock_stepper_pkg::*;
#(
    parameter int DIV_FACTOR      = 1_200_000,
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn_n,
    input  logic        halt,
    output logic        clk_en,
    output logic        run_active,
`ifdef CLOCK_STEPPER_COUNT_EN
    output logic [15:0] step_count,
`endif
    output logic        btn_stable
);

    localparam int DW = count_width(DIV_FACTOR);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_FACTOR - 1);

    logic [SYNC_STAGES-1:0] run_sync;
    logic                   mode_chg;
    logic                   mode_chg_d;
    logic [DW-1:0]          divider;
    logic                   run_tick;
    logic                   btn_prev;
    logic                   btn_rise;
    logic                   pulse_req;
    logic                   en_next;
    step_state_t            state;
    step_state_t            next_state;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk   (clk),
        .reset (reset),
        .btn_n (step_btn_n),
        .stable(btn_stable)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_sync   <= '0;
            run_active <= 1'b0;
            mode_chg_d <= 1'b0;
        end else begin
            run_sync   <= {run_sync[SYNC_STAGES-2:0], run_sw};
            run_active <= run_sync[SYNC_STAGES-1];
            mode_chg_d <= mode_chg;
        end
    end

    // High on the edge at which run_active is about to toggle.
    assign mode_chg = run_sync[SYNC_STAGES-1] ^ run_active;

    // Divider free-runs through halt and step mode; only a mode change clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider <= '0;
        end else if (mode_chg || divider == DIV_LAST) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    assign run_tick = run_active & (divider == DIV_LAST);
    assign btn_rise = btn_stable & ~btn_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            btn_prev <= 1'b0;
        end else begin
            state    <= next_state;
            btn_prev <= btn_stable;
        end
    end

    // Parked in S_IDLE during run mode; edge detection means a button held
    // across a switch to step mode must be released before it can step.
    always_comb begin
        next_state = state;
        pulse_req  = 1'b0;
        if (mode_chg || run_active) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn_rise) begin
                        next_state = halt ? S_WAIT_REL : S_PULSE;
                    end
                end
                S_PULSE: begin
                    pulse_req  = ~halt;
                    next_state = S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!btn_stable) begin
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    assign en_next = ~halt & ~mode_chg & ~mode_chg_d & (run_active ? run_tick : pulse_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_en <= 1'b0;
        end else begin
            clk_en <= en_next;
        end
    end

`ifdef CLOCK_STEPPER_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count <= 16'd0;
        end else if (clk_en) begin
            step_count <= step_count + 16'd1;
        end
    end
`endif

endmodule
